// File: rtl/alu_pkg.sv
// Shared opcode map and controller state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_INC_A = 4'h0;
    localparam logic [3:0] OP_DEC_A = 4'h1;
    localparam logic [3:0] OP_DBL_A = 4'h2;
    localparam logic [3:0] OP_INC_B = 4'h3;
    localparam logic [3:0] OP_DEC_B = 4'h4;
    localparam logic [3:0] OP_DBL_B = 4'h5;
    localparam logic [3:0] OP_ADD   = 4'h6;
    localparam logic [3:0] OP_MUL   = 4'h7;
    localparam logic [3:0] OP_NOT_A = 4'h8;
    localparam logic [3:0] OP_NOT_B = 4'h9;
    localparam logic [3:0] OP_AND   = 4'hA;
    localparam logic [3:0] OP_OR    = 4'hB;
    localparam logic [3:0] OP_XOR   = 4'hC;
    localparam logic [3:0] OP_XNOR  = 4'hD;
    localparam logic [3:0] OP_NAND  = 4'hE;
    localparam logic [3:0] OP_NOR   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH cycles.
// done/product are presented combinationally during the final iteration so the parent can register them.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
    end

    assign done    = busy && (cnt == CW'(1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with double-width registered result and zero/carry flags.
// Single-cycle ops resolve in one edge; multiply runs through alu_mul_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 zero,
    output logic                 carry
);

    localparam int W2 = 2 * WIDTH;

    // Returns {carry, result}; operands are zero-extended so arithmetic wraps at 2*WIDTH bits.
    function automatic logic [W2:0] alu_eval(input logic [3:0] opc,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv);
        logic [W2-1:0] ax;
        logic [W2-1:0] bx;
        logic [W2-1:0] r;
        logic          c;
        ax = {{WIDTH{1'b0}}, av};
        bx = {{WIDTH{1'b0}}, bv};
        r  = '0;
        c  = 1'b0;
        case (opc)
            OP_INC_A: begin r = ax + W2'(1); c = r[WIDTH]; end
            OP_DEC_A: begin r = ax - W2'(1); c = (av == '0); end
            OP_DBL_A: begin r = ax << 1;     c = r[WIDTH]; end
            OP_INC_B: begin r = bx + W2'(1); c = r[WIDTH]; end
            OP_DEC_B: begin r = bx - W2'(1); c = (bv == '0); end
            OP_DBL_B: begin r = bx << 1;     c = r[WIDTH]; end
            OP_ADD:   begin r = ax + bx;     c = r[WIDTH]; end
            OP_NOT_A: r = {{WIDTH{1'b0}}, ~av};
            OP_NOT_B: r = {{WIDTH{1'b0}}, ~bv};
            OP_AND:   r = {{WIDTH{1'b0}}, av & bv};
            OP_OR:    r = {{WIDTH{1'b0}}, av | bv};
            OP_XOR:   r = {{WIDTH{1'b0}}, av ^ bv};
            OP_XNOR:  r = {{WIDTH{1'b0}}, ~(av ^ bv)};
            OP_NAND:  r = {{WIDTH{1'b0}}, ~(av & bv)};
            OP_NOR:   r = {{WIDTH{1'b0}}, ~(av | bv)};
            default:  r = '0;
        endcase
        return {c, r};
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            is_mul;
    logic [W2:0]     alu_res;
    logic            mul_done;
    logic [W2-1:0]   mul_prod;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign alu_res   = alu_eval(op, a, b);
    assign out_valid = (state == S_DONE);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (mul_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                // Consuming and accepting on the same edge chains straight into the next op.
                if (accept)         state_nxt = is_mul ? S_MUL : S_DONE;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            y     <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && !is_mul) begin
                y     <= alu_res[W2-1:0];
                carry <= alu_res[W2];
                zero  <= (alu_res[W2-1:0] == '0);
            end else if ((state == S_MUL) && mul_done) begin
                y     <= mul_prod;
                carry <= |mul_prod[W2-1:WIDTH];
                zero  <= (mul_prod == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq at WIDTH = 4, 8 and 16 with a result scoreboard per instance.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, zero4, carry4;
    logic [3:0]  a4 = '0, b4 = '0, op4 = '0;
    logic [7:0]  y4;
    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, zero8, carry8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  op8 = '0;
    logic [15:0] y8;
    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16, zero16, carry16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  op16 = '0;
    logic [31:0] y16;
    logic        bp16 = 1'b0;

    alu_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
        .y(y4), .zero(zero4), .carry(carry4));

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .zero(zero8), .carry(carry8));

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .y(y16), .zero(zero16), .carry(carry16));

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard entries: {zero, carry, y zero-extended to 64 bits}
    logic [65:0] q4[$];
    logic [65:0] q8[$];
    logic [65:0] q16[$];

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] model(input int w, input logic [3:0] opc,
                                          input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] m2, mw, ax, bx, r;
        logic        c;
        m2 = (64'd1 << (2 * w)) - 64'd1;
        mw = (64'd1 << w) - 64'd1;
        ax = {32'd0, av} & mw;
        bx = {32'd0, bv} & mw;
        r  = '0;
        c  = 1'b0;
        case (opc)
            4'h0: begin r = (ax + 64'd1) & m2; c = r[w]; end
            4'h1: begin r = (ax - 64'd1) & m2; c = (ax == 64'd0); end
            4'h2: begin r = (ax * 64'd2) & m2; c = r[w]; end
            4'h3: begin r = (bx + 64'd1) & m2; c = r[w]; end
            4'h4: begin r = (bx - 64'd1) & m2; c = (bx == 64'd0); end
            4'h5: begin r = (bx * 64'd2) & m2; c = r[w]; end
            4'h6: begin r = (ax + bx) & m2;    c = r[w]; end
            4'h7: begin r = (ax * bx) & m2;    c = ((r >> w) != 64'd0); end
            4'h8: r = ~ax & mw;
            4'h9: r = ~bx & mw;
            4'hA: r = ax & bx;
            4'hB: r = ax | bx;
            4'hC: r = ax ^ bx;
            4'hD: r = ~(ax ^ bx) & mw;
            4'hE: r = ~(ax & bx) & mw;
            default: r = ~(ax | bx) & mw;
        endcase
        return {(r == 64'd0), c, r};
    endfunction

    function automatic logic ready_of(input int w);
        case (w)
            4:       return in_ready4;
            8:       return in_ready8;
            default: return in_ready16;
        endcase
    endfunction

    // Call aligned just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int w, input logic [3:0] opc, input logic [31:0] av, input logic [31:0] bv);
        logic got;
        got = 1'b0;
        case (w)
            4:       begin in_valid4  = 1'b1; op4  = opc; a4  = av[3:0];  b4  = bv[3:0];  end
            8:       begin in_valid8  = 1'b1; op8  = opc; a8  = av[7:0];  b8  = bv[7:0];  end
            default: begin in_valid16 = 1'b1; op16 = opc; a16 = av[15:0]; b16 = bv[15:0]; end
        endcase
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ready_of(w)) begin
                got = 1'b1;
                case (w)
                    4:       q4.push_back(model(w, opc, av, bv));
                    8:       q8.push_back(model(w, opc, av, bv));
                    default: q16.push_back(model(w, opc, av, bv));
                endcase
            end
            @(posedge clk); #1;
        end
        case (w)
            4:       in_valid4  = 1'b0;
            8:       in_valid8  = 1'b0;
            default: in_valid16 = 1'b0;
        endcase
        check("accept_wait", 66'(got), 66'(1));
    endtask

    always @(posedge clk) begin
        #1;
        out_ready16 = bp16 ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) check("u4_extra", 66'(1), 66'(0));
            else check("u4_result", {zero4, carry4, 64'(y4)}, q4.pop_front());
        end
        if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) check("u8_extra", 66'(1), 66'(0));
            else check("u8_result", {zero8, carry8, 64'(y8)}, q8.pop_front());
        end
        if (out_valid16 && out_ready16) begin
            if (q16.size() == 0) check("u16_extra", 66'(1), 66'(0));
            else check("u16_result", {zero16, carry16, 64'(y16)}, q16.pop_front());
        end
    end

    initial begin
        logic [65:0] dropped;
        logic [31:0] ra, rb;

        // reset state on all instances
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_u4",  66'({in_ready4,  out_valid4,  zero4,  carry4,  y4}),  66'({4'b1000, 8'h0}));
        check("rst_u8",  66'({in_ready8,  out_valid8,  zero8,  carry8,  y8}),  66'({4'b1000, 16'h0}));
        check("rst_u16", 66'({in_ready16, out_valid16, zero16, carry16, y16}), 66'({4'b1000, 32'h0}));
        @(posedge clk); #1;

        // decrement of zero borrows and fills all 2*WIDTH bits
        issue(4, OP_DEC_A, 0, 0);
        @(negedge clk);
        check("dec_zero", 66'({out_valid4, zero4, carry4, y4}), 66'({3'b101, 8'hFF}));
        @(posedge clk); #1;

        issue(4, OP_ADD, 15, 15);
        @(negedge clk);
        check("add_15_15", 66'({out_valid4, zero4, carry4, y4}), 66'({3'b101, 8'd30}));
        @(posedge clk); #1;
        issue(4, OP_NOR, 5, 10);
        @(negedge clk);
        check("nor_zero", 66'({out_valid4, zero4, carry4, y4}), 66'({3'b110, 8'h00}));
        @(posedge clk); #1;

        // WIDTH=8 multiply: in_ready low for 8 cycles, result visible on the 9th
        issue(8, OP_MUL, 200, 150);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mul8_busy", 66'({in_ready8, out_valid8}), 66'(0));
        end
        @(negedge clk);
        check("mul8_result", 66'({out_valid8, carry8, y8}), 66'({2'b11, 16'd30000}));
        @(posedge clk); #1;

        // result held under back-pressure, then consumed together with a new accept
        out_ready4 = 1'b0;
        issue(4, OP_ADD, 3, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stable", 66'({out_valid4, in_ready4, zero4, carry4, y4}), 66'({4'b1000, 8'd7}));
            @(posedge clk); #1;
        end
        out_ready4 = 1'b1;
        issue(4, OP_INC_A, 7, 0);
        @(negedge clk);
        check("chain_inc", 66'({out_valid4, y4}), 66'({1'b1, 8'd8}));
        @(posedge clk); #1;

        // reset during the 3rd multiply cycle aborts it
        issue(4, OP_MUL, 9, 9);
        dropped = q4.pop_back();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_busy", 66'(out_valid4), 66'(0));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 66'(out_valid4), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_reset", 66'({in_ready4, out_valid4, zero4, carry4, y4}), 66'({4'b1000, 8'h0}));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", 66'(out_valid4), 66'(0));
        end
        @(posedge clk); #1;

        // opcode sweeps: all-ones, zeros and random operands
        for (int o = 0; o < 16; o++) begin
            for (int k = 0; k < 3; k++) begin
                ra = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'd0 : $urandom;
                rb = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'd0 : $urandom;
                issue(4, 4'(o), ra, rb);
            end
        end
        for (int o = 0; o < 16; o++) begin
            for (int k = 0; k < 3; k++) begin
                ra = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'd0 : $urandom;
                rb = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'd0 : $urandom;
                issue(16, 4'(o), ra, rb);
            end
        end
        bp16 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            issue(16, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        bp16 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("drain_u4",  66'(q4.size()),  66'(0));
        check("drain_u8",  66'(q8.size()),  66'(0));
        check("drain_u16", 66'(q16.size()), 66'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It keeps the same 16-entry opcode map, generalised to `WIDTH`-bit operands, with a double-width registered result, zero and carry flags, and a true `A*B` multiply executed iteratively. It sits between an operand/opcode source and a result consumer, using valid/ready on both sides.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2–32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and opcode are valid.
- `in_ready` output 1: block can accept an operation this cycle.
- `a` input `WIDTH`: operand A.
- `b` input `WIDTH`: operand B.
- `op` input 4: opcode, see Operation.
- `out_valid` output 1: `y` and the flags hold a result.
- `out_ready` input 1: consumer takes the result this cycle.
- `y` output `2*WIDTH`: result.
- `zero` output 1: `y == 0`.
- `carry` output 1: carry, borrow or overflow indication, per opcode.

## Operation
- An operation is accepted on an edge where `in_valid && in_ready`. `a`, `b` and `op` are captured on that edge.
- Opcode map:
  - 0000: A+1
  - 0001: A−1
  - 0010: 2A
  - 0011: B+1
  - 0100: B−1
  - 0101: 2B
  - 0110: A+B
  - 0111: A·B (multi-cycle)
  - 1000: ~A
  - 1001: ~B
  - 1010: A&B
  - 1011: A|B
  - 1100: A^B
  - 1101: ~(A^B)
  - 1110: ~(A&B)
  - 1111: ~(A|B)
- Width rules:
  - Operands are zero-extended to `2*WIDTH` bits. Arithmetic wraps modulo 2^(2·WIDTH).
  - Logic ops compute `WIDTH` bits; `y[2W-1:W]` is 0.
- `carry` rules:
  - Add and double ops: `carry = y[WIDTH]`, i.e. the result overflowed `WIDTH` bits.
  - Decrement ops: `carry = 1` iff the operand was 0 (borrow). In that case `y` is all-ones over `2*WIDTH` bits.
  - Multiply: `carry = |y[2W-1:W]`.
  - Logic ops: `carry = 0`.
- State machine:
  - IDLE: `in_ready = 1`. On accept of op 0111, go to MUL. On accept of any other op, register the result and flags and go to DONE.
  - MUL: shift-add over `WIDTH` iterations, one iteration per cycle; `in_ready = 0`. After the last iteration, go to DONE.
  - DONE: `out_valid = 1`; `y`, `zero` and `carry` are held stable.
    - `out_ready = 1` and no new accept: go to IDLE.
    - `in_ready = out_ready` in DONE. An accept in the same cycle as the result is consumed is legal; the next state is then DONE (single-cycle op) or MUL (multiply).
- Reset values: state IDLE, `out_valid = 0`, `y = 0`, `zero = 0`, `carry = 0`, multiplier registers 0. `in_ready = 1` in the first cycle after reset.
- Reset asserted in MUL or DONE aborts the operation. No `out_valid` is produced for it, and the result is discarded.
- `in_valid` while `in_ready = 0` is ignored. The source must hold its values; no capture happens.

## Timing
- Single-cycle op accepted at edge k: `out_valid` is high from edge k+1.
- Multiply accepted at edge k: `out_valid` is high from edge k+`WIDTH`+1 (`WIDTH` iterations plus the transition into DONE).
- Back-to-back single-cycle ops with `out_ready` held high give one result per cycle.
- `in_ready` is combinational from state and `out_ready`. All other outputs are registered.
- `zero` and `carry` change only on the edge that loads `y`.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`OP_INC_A` … `OP_NOR`)
  - state enum (`S_IDLE`, `S_MUL`, `S_DONE`)
- One sub-module, `alu_mul_iter`: iterative shift-add multiplier.
  - Inputs: `start`, `a`, `b`.
  - Outputs: `done` and a product of width `2*WIDTH`.
  - Same clock and reset as the parent.
- The single-cycle datapath is a combinational function inside `alu_seq`.

## Test plan
- WIDTH=4, op 0001, a=0: `y` = 0xFF, `carry` = 1, `zero` = 0; `out_valid` high one cycle after accept.
- WIDTH=4, op 0110, a=15, b=15: `y` = 30, `carry` = 1. Op 1111, a=5, b=10: `y` = 0x00, `zero` = 1, `carry` = 0.
- WIDTH=8, op 0111, a=200, b=150: `in_ready` is low for 8 cycles, then `y` = 30000, `carry` = 1; `out_valid` at accept+9.
- Hold `out_ready` low for 5 cycles in DONE: `y` and flags are stable and `in_ready` stays 0. Then raise `out_ready` together with `in_valid` carrying op 0000, a=7: the result is consumed, `y` = 8 appears the next cycle.
- Assert `rst` in the 3rd cycle of a WIDTH=4 multiply: `out_valid` never rises for it, all outputs read 0, and `in_ready` = 1 the next cycle.
- Sweep all 16 opcodes with random a/b at WIDTH=4 and WIDTH=16: `y`, `zero` and `carry` match the reference model on every `out_valid && out_ready`, with no lost or duplicated results.
